// File: rtl/rf_pkg.sv
// Shared types and helpers for the banked physical register file.
package rf_pkg;

    localparam int unsigned MaxDepth    = 1024;
    localparam int unsigned DefBankBits = 2;
    localparam int unsigned DefRowBits  = 5;

    typedef enum logic [0:0] {
        StInit,
        StReady
    } rf_state_e;

    function automatic int unsigned bank_bits(input int unsigned num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int unsigned row_bits(input int unsigned index, input int unsigned num_banks);
        return index - $clog2(num_banks);
    endfunction

    // Callers truncate the result to their own DEPTH.
    function automatic logic [MaxDepth-1:0] onehot(input int unsigned addr);
        logic [MaxDepth-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/banked_phys_reg_file_if.sv
// Read/write port bundle of the banked physical register file.
interface banked_phys_reg_file_if #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned INDEX  = 7,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_RD = 12,
    parameter int unsigned NUM_WR = 6
);
    logic [NUM_RD*INDEX-1:0] rd_addr_i;
    logic [NUM_RD*WIDTH-1:0] rd_data_o;
    logic [NUM_RD*DEPTH-1:0] rd_decoded_o;
    logic [NUM_WR-1:0]       wr_en_i;
    logic [NUM_WR*INDEX-1:0] wr_addr_i;
    logic [NUM_WR*WIDTH-1:0] wr_data_i;
    logic [NUM_WR*DEPTH-1:0] wr_decoded_o;
    logic                    ready_o;

    modport master (
        output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
        input  rd_data_o, rd_decoded_o, wr_decoded_o, ready_o
    );

    modport slave (
        input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
        output rd_data_o, rd_decoded_o, wr_decoded_o, ready_o
    );

endinterface

// File: rtl/rf_bank.sv
// One storage bank: multi-write (last enabled port wins), combinational multi-read.
module rf_bank #(
    parameter int unsigned ROWS   = 32,
    parameter int unsigned ROW_W  = 5,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_RD = 12,
    parameter int unsigned NUM_WR = 6
) (
    input  logic                    clk,
    input  logic                    init_i,
    input  logic [ROW_W-1:0]        init_row_i,
    input  logic [NUM_WR-1:0]       wr_en_i,
    input  logic [NUM_WR*ROW_W-1:0] wr_row_i,
    input  logic [NUM_WR*WIDTH-1:0] wr_data_i,
    input  logic [NUM_RD*ROW_W-1:0] rd_row_i,
    output logic [NUM_RD*WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [ROWS];

    // Storage is deliberately not reset; the init sweep clears it.
    always_ff @(posedge clk) begin
        if (init_i) begin
            mem_q[init_row_i] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w]) begin
                    mem_q[wr_row_i[w*ROW_W +: ROW_W]] <= wr_data_i[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data_o[p*WIDTH +: WIDTH] = mem_q[rd_row_i[p*ROW_W +: ROW_W]];
        end
    end

endmodule

// File: rtl/banked_phys_reg_file.sv
// Banked physical register file with init sweep, registered reads and write priority.
// Optional macro RF_BYPASS_EN forwards same-edge write data to reads of that address.
module banked_phys_reg_file
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned INDEX     = 7,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned NUM_RD    = 12,
    parameter int unsigned NUM_WR    = 6
) (
    input logic                   clk,
    input logic                   reset,
    banked_phys_reg_file_if.slave rf_bus
);

    localparam int unsigned BankW = bank_bits(NUM_BANKS);
    localparam int unsigned RowW  = row_bits(INDEX, NUM_BANKS);
    localparam int unsigned Rows  = DEPTH / NUM_BANKS;
    localparam int unsigned SelW  = (BankW == 0) ? 1 : BankW;

    rf_state_e               state_q, state_d;
    logic [RowW-1:0]         sweep_q, sweep_d;
    logic [NUM_RD*WIDTH-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD*DEPTH-1:0] rd_dec_q, rd_dec_d;
    logic                    ready;
    logic                    init_active;

    logic [NUM_WR-1:0]       wr_eff;
    logic [NUM_WR*RowW-1:0]  wr_row;
    logic [SelW-1:0]         wr_bank [NUM_WR];
    logic [NUM_RD*RowW-1:0]  rd_row;
    logic [NUM_RD*WIDTH-1:0] bank_rdata [NUM_BANKS];

    assign ready       = (state_q == StReady);
    assign init_active = (state_q == StInit);

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            StInit: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == RowW'(Rows - 1)) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StInit;
            sweep_q   <= '0;
            rd_data_q <= '0;
            rd_dec_q  <= '0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            rd_data_q <= rd_data_d;
            rd_dec_q  <= rd_dec_d;
        end
    end

    // A port commits only if no higher-indexed port writes the same address this cycle.
    always_comb begin
        wr_eff = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_eff[w] = rf_bus.wr_en_i[w] & ready;
            for (int v = 0; v < NUM_WR; v++) begin
                if (v > w && rf_bus.wr_en_i[v] &&
                    rf_bus.wr_addr_i[v*INDEX +: INDEX] == rf_bus.wr_addr_i[w*INDEX +: INDEX]) begin
                    wr_eff[w] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic [INDEX-1:0] wa;
        wr_row = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wa                     = rf_bus.wr_addr_i[w*INDEX +: INDEX];
            wr_row[w*RowW +: RowW] = RowW'(wa);
            wr_bank[w]             = SelW'(wa >> RowW);
        end
    end

    always_comb begin
        rd_row = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_row[p*RowW +: RowW] = RowW'(rf_bus.rd_addr_i[p*INDEX +: INDEX]);
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [NUM_WR-1:0] bank_we;

        always_comb begin
            bank_we = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                bank_we[w] = wr_eff[w] && (wr_bank[w] == SelW'(b));
            end
        end

        rf_bank #(
            .ROWS   (Rows),
            .ROW_W  (RowW),
            .WIDTH  (WIDTH),
            .NUM_RD (NUM_RD),
            .NUM_WR (NUM_WR)
        ) u_bank (
            .clk        (clk),
            .init_i     (init_active),
            .init_row_i (sweep_q),
            .wr_en_i    (bank_we),
            .wr_row_i   (wr_row),
            .wr_data_i  (rf_bus.wr_data_i),
            .rd_row_i   (rd_row),
            .rd_data_o  (bank_rdata[b])
        );
    end

    always_comb begin
        logic [INDEX-1:0] ra;
        logic [SelW-1:0]  rsel;
        logic [WIDTH-1:0] word;
        rd_data_d = '0;
        rd_dec_d  = '0;
        ra        = '0;
        rsel      = '0;
        word      = '0;
        if (ready) begin
            for (int p = 0; p < NUM_RD; p++) begin
                ra   = rf_bus.rd_addr_i[p*INDEX +: INDEX];
                rsel = SelW'(ra >> RowW);
                word = '0;
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (rsel == SelW'(b)) begin
                        word = bank_rdata[b][p*WIDTH +: WIDTH];
                    end
                end
`ifdef RF_BYPASS_EN
                // wr_eff has at most one port per address, so this is the winning writer.
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_eff[w] && rf_bus.wr_addr_i[w*INDEX +: INDEX] == ra) begin
                        word = rf_bus.wr_data_i[w*WIDTH +: WIDTH];
                    end
                end
`endif
                rd_data_d[p*WIDTH +: WIDTH] = word;
                rd_dec_d[p*DEPTH +: DEPTH]  = DEPTH'(onehot(32'(ra)));
            end
        end
    end

    always_comb begin
        rf_bus.wr_decoded_o = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (rf_bus.wr_en_i[w] && ready) begin
                rf_bus.wr_decoded_o[w*DEPTH +: DEPTH] =
                    DEPTH'(onehot(32'(rf_bus.wr_addr_i[w*INDEX +: INDEX])));
            end
        end
    end

    assign rf_bus.rd_data_o    = rd_data_q;
    assign rf_bus.rd_decoded_o = rd_dec_q;
    assign rf_bus.ready_o      = ready;

endmodule
